// File: rtl/fetch_translate_cache_pkg.sv
// Shared types and constants for the instruction-side fetch front end:
// controller states, ITLB entry layout, and page/line geometry.
package fetch_translate_cache_pkg;

   localparam int PAGE_BITS        = 12;
   localparam int VPN_BITS         = 32 - PAGE_BITS;
   localparam int LINE_OFFSET_BITS = 4;
   localparam int WORD_SEL_LSB     = 2;

   typedef enum logic [1:0] {
      LOOKUP   = 2'd0,
      TLB_FILL = 2'd1,
      MEM_WAIT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic                valid;
      logic [VPN_BITS-1:0] vpn;
      logic [VPN_BITS-1:0] ppn;
   } itlb_entry_t;

endpackage

// File: rtl/fetch_translate_cache_itlb_array.sv
// Fully-associative ITLB: entry storage, combinational VPN lookup and a
// single fill port that writes at a round-robin victim pointer.
module itlb_array
   import fetch_translate_cache_pkg::*;
#(
   parameter int TLB_ENTRIES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [VPN_BITS-1:0] lookup_vpn,
   input  logic                fill_en,
   input  logic [VPN_BITS-1:0] fill_vpn,
   input  logic [VPN_BITS-1:0] fill_ppn,
   output logic                hit,
   output logic [VPN_BITS-1:0] hit_ppn
);

   localparam int PTR_BITS = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

   itlb_entry_t         entries_r [TLB_ENTRIES];
   logic [PTR_BITS-1:0] rr_ptr_r;

   // Match every valid entry against the VPN; fills only occur on a miss,
   // so at most one entry matches and OR-merging the PPNs is safe.
   always_comb begin
      hit     = 1'b0;
      hit_ppn = '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         hit     = hit | (entries_r[i].valid & (entries_r[i].vpn == lookup_vpn));
         hit_ppn = hit_ppn | (entries_r[i].ppn &
                   {VPN_BITS{entries_r[i].valid & (entries_r[i].vpn == lookup_vpn)}});
      end
   end

   // Write the new translation at the victim pointer, then advance it with wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < TLB_ENTRIES; i++) begin
            entries_r[i] <= '0;
         end
         rr_ptr_r <= '0;
      end else if (fill_en) begin
         entries_r[rr_ptr_r] <= '{valid: 1'b1, vpn: fill_vpn, ppn: fill_ppn};
         if (rr_ptr_r == PTR_BITS'(TLB_ENTRIES - 1)) begin
            rr_ptr_r <= '0;
         end else begin
            rr_ptr_r <= rr_ptr_r + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_translate_cache.sv
// Fetch-side memory front end: ITLB translation with an offset-based miss
// handler, a direct-mapped read-only instruction cache and the controlling FSM.
module fetch_translate_cache #(
   parameter int CACHE_LINE_SIZE = 128,
   parameter int NUM_LINES       = 4,
   parameter int TLB_ENTRIES     = 4,
   parameter int PAGE_BITS       = 12
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_read_en,
   input  logic [31:0]                in_addr,
   input  logic [31:0]                in_os_offset,
   input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
   input  logic                       in_mem_ready,
   output logic [31:0]                out_read_data,
   output logic                       out_busy,
   output logic                       out_hit,
   output logic                       out_mem_read_en,
   output logic                       out_mem_write_en,
   output logic [31:0]                out_mem_addr,
   output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data
);

   import fetch_translate_cache_pkg::*;

   localparam int OFF_BITS   = LINE_OFFSET_BITS;
   localparam int INDEX_BITS = $clog2(NUM_LINES);
   localparam int TAG_LSB    = OFF_BITS + INDEX_BITS;
   localparam int TAG_BITS   = 32 - TAG_LSB;
   localparam int VPN_W      = 32 - PAGE_BITS;

   fetch_state_t               state_r;
   logic                       mem_read_en_r;
   logic [31:0]                mem_addr_r;
   logic [CACHE_LINE_SIZE-1:0] line_data_r [NUM_LINES];
   logic [TAG_BITS-1:0]        line_tag_r  [NUM_LINES];
   logic [NUM_LINES-1:0]       line_valid_r;

   logic                       tlb_hit_s;
   logic [VPN_W-1:0]           tlb_ppn_s;
   logic                       tlb_fill_s;
   logic [31:0]                miss_pa_s;
   logic [31:0]                pa_s;
   logic [INDEX_BITS-1:0]      pa_index_s;
   logic [TAG_BITS-1:0]        pa_tag_s;
   logic                       cache_hit_s;
   logic                       hit_s;
   logic                       fill_done_s;
   logic [INDEX_BITS-1:0]      fill_index_s;
   logic [TAG_BITS-1:0]        fill_tag_s;
   logic [31:0]                word_s;
   logic                       unused_s;

   // Miss handler translation wraps modulo 2^32.
   assign miss_pa_s  = in_addr + in_os_offset;
   assign tlb_fill_s = (state_r == TLB_FILL);

   itlb_array #(
      .TLB_ENTRIES (TLB_ENTRIES)
   ) u_itlb (
      .clk        (clk),
      .reset      (reset),
      .lookup_vpn (in_addr[31:PAGE_BITS]),
      .fill_en    (tlb_fill_s),
      .fill_vpn   (in_addr[31:PAGE_BITS]),
      .fill_ppn   (miss_pa_s[31:PAGE_BITS]),
      .hit        (tlb_hit_s),
      .hit_ppn    (tlb_ppn_s)
   );

   assign pa_s        = {tlb_ppn_s, in_addr[PAGE_BITS-1:0]};
   assign pa_index_s  = pa_s[TAG_LSB-1:OFF_BITS];
   assign pa_tag_s    = pa_s[31:TAG_LSB];
   assign cache_hit_s = line_valid_r[pa_index_s] && (line_tag_r[pa_index_s] == pa_tag_s);
   assign hit_s       = tlb_hit_s && cache_hit_s && (state_r == LOOKUP);

   // Refill targets the line latched at miss detection, not the live address.
   assign fill_done_s  = (state_r == MEM_WAIT) && in_mem_ready;
   assign fill_index_s = mem_addr_r[TAG_LSB-1:OFF_BITS];
   assign fill_tag_s   = mem_addr_r[31:TAG_LSB];

   // Select the addressed little-endian word of the indexed line.
   always_comb begin
      word_s = line_data_r[pa_index_s][{pa_s[OFF_BITS-1:WORD_SEL_LSB], 5'd0} +: 32];
   end

   assign out_read_data      = hit_s ? word_s : 32'd0;
   assign out_hit            = hit_s;
   assign out_busy           = in_read_en & ~hit_s;
   assign out_mem_read_en    = mem_read_en_r;
   assign out_mem_addr       = mem_addr_r;
   assign out_mem_write_en   = 1'b0;
   assign out_mem_write_data = '0;
   assign unused_s           = ^{miss_pa_s[PAGE_BITS-1:0], pa_s[WORD_SEL_LSB-1:0]};

   // Fetch controller: sequences TLB refill and line refill, owns the memory request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= LOOKUP;
         mem_read_en_r <= 1'b0;
         mem_addr_r    <= 32'd0;
      end else begin
         case (state_r)
            LOOKUP: begin
               if (in_read_en && !tlb_hit_s) begin
                  state_r <= TLB_FILL;
               end else if (in_read_en && !cache_hit_s) begin
                  state_r       <= MEM_WAIT;
                  mem_read_en_r <= 1'b1;
                  mem_addr_r    <= {pa_s[31:OFF_BITS], {OFF_BITS{1'b0}}};
               end else begin
                  state_r <= LOOKUP;
               end
            end
            TLB_FILL: begin
               state_r <= LOOKUP;
            end
            MEM_WAIT: begin
               if (in_mem_ready) begin
                  state_r       <= LOOKUP;
                  mem_read_en_r <= 1'b0;
               end else begin
                  state_r <= MEM_WAIT;
               end
            end
            default: begin
               state_r       <= LOOKUP;
               mem_read_en_r <= 1'b0;
            end
         endcase
      end
   end

   // Cache storage: whole-line write of data, tag and valid on refill completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            line_data_r[i] <= '0;
            line_tag_r[i]  <= '0;
         end
         line_valid_r <= '0;
      end else if (fill_done_s) begin
         line_data_r[fill_index_s]  <= in_mem_read_data;
         line_tag_r[fill_index_s]   <= fill_tag_s;
         line_valid_r[fill_index_s] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_translate_cache.sv
// Randomized self-checking bench for fetch_translate_cache against a
// transaction-level model of the ITLB, cache contents and memory.
module tb_fetch_translate_cache;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_read_en;
   logic [31:0]  in_addr;
   logic [31:0]  in_os_offset;
   logic [127:0] in_mem_read_data;
   logic         in_mem_ready;
   logic [31:0]  out_read_data;
   logic         out_busy;
   logic         out_hit;
   logic         out_mem_read_en;
   logic         out_mem_write_en;
   logic [31:0]  out_mem_addr;
   logic [127:0] out_mem_write_data;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit        m_tlb_valid [4];
   bit [19:0] m_tlb_vpn   [4];
   bit [19:0] m_tlb_ppn   [4];
   int        m_rr;
   bit        m_line_valid [4];
   bit [31:0] m_line_addr  [4];
   bit [127:0] mem_override [bit [31:0]];

   fetch_translate_cache dut (
      .clk                (clk),
      .reset              (reset),
      .in_read_en         (in_read_en),
      .in_addr            (in_addr),
      .in_os_offset       (in_os_offset),
      .in_mem_read_data   (in_mem_read_data),
      .in_mem_ready       (in_mem_ready),
      .out_read_data      (out_read_data),
      .out_busy           (out_busy),
      .out_hit            (out_hit),
      .out_mem_read_en    (out_mem_read_en),
      .out_mem_write_en   (out_mem_write_en),
      .out_mem_addr       (out_mem_addr),
      .out_mem_write_data (out_mem_write_data)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit [127:0] mem_line(input bit [31:0] line);
      if (mem_override.exists(line)) begin
         return mem_override[line];
      end
      return {line ^ 32'h5a5a_0f0f, line + 32'h0101_0101, ~line, line * 32'd7 + 32'd3};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_tlb_valid[i]  = 1'b0;
         m_line_valid[i] = 1'b0;
      end
      m_rr = 0;
   endtask

   task automatic model_translate(input bit [31:0] va, output bit hit, output bit [19:0] ppn);
      hit = 1'b0;
      ppn = 20'd0;
      for (int i = 0; i < 4; i++) begin
         if (m_tlb_valid[i] && m_tlb_vpn[i] == va[31:12]) begin
            hit = 1'b1;
            ppn = m_tlb_ppn[i];
         end
      end
   endtask

   // One fetch from request to data, checking every cycle. Starts and ends at posedge+1.
   task automatic do_fetch(input bit [31:0] va, input bit [31:0] off, input int lat);
      bit        hit;
      bit [19:0] ppn;
      bit [31:0] pa, line, sum, word;
      int        idx;
      bit [127:0] d;
      in_addr          = va;
      in_os_offset     = off;
      in_read_en       = 1'b1;
      in_mem_ready     = 1'($urandom_range(0, 1));
      in_mem_read_data = {$urandom, $urandom, $urandom, $urandom};
      model_translate(va, hit, ppn);
      if (!hit) begin
         @(negedge clk);
         check_value("tlb_miss_busy", out_busy, 1);
         check_value("tlb_miss_hit", out_hit, 0);
         @(posedge clk); #1;
         @(negedge clk);
         check_value("tlb_fill_busy", out_busy, 1);
         check_value("tlb_fill_req", out_mem_read_en, 0);
         @(posedge clk); #1;
         sum = va + off;
         m_tlb_valid[m_rr] = 1'b1;
         m_tlb_vpn[m_rr]   = va[31:12];
         m_tlb_ppn[m_rr]   = sum[31:12];
         m_rr = (m_rr + 1) % 4;
         ppn = sum[31:12];
      end
      pa   = {ppn, va[11:0]};
      line = pa & ~32'hF;
      idx  = int'((line >> 4) % 4);
      if (!(m_line_valid[idx] && m_line_addr[idx] == line)) begin
         @(negedge clk);
         check_value("cache_miss_busy", out_busy, 1);
         check_value("cache_miss_req_early", out_mem_read_en, 0);
         @(posedge clk); #1;
         for (int k = 0; k <= lat; k++) begin
            in_mem_ready     = (k == lat);
            in_mem_read_data = (k == lat) ? mem_line(line) : {$urandom, $urandom, $urandom, $urandom};
            in_addr          = $urandom & 32'hFFFF_FFFC;
            @(negedge clk);
            check_value("mem_req", out_mem_read_en, 1);
            check_value("mem_addr", out_mem_addr, line);
            check_value("mem_wait_busy", out_busy, 1);
            @(posedge clk); #1;
         end
         in_addr          = va;
         in_mem_ready     = 1'($urandom_range(0, 1));
         in_mem_read_data = {$urandom, $urandom, $urandom, $urandom};
         m_line_valid[idx] = 1'b1;
         m_line_addr[idx]  = line;
      end
      d    = mem_line(line);
      word = d[32 * pa[3:2] +: 32];
      @(negedge clk);
      check_value("hit_busy", out_busy, 0);
      check_value("hit_flag", out_hit, 1);
      check_value("hit_data", out_read_data, word);
      check_value("req_dropped", out_mem_read_en, 0);
      @(posedge clk); #1;
   endtask

   // Idle cycles with random address and stray ready pulses; nothing may change.
   task automatic do_idle(input int n);
      for (int i = 0; i < n; i++) begin
         in_read_en       = 1'b0;
         in_addr          = $urandom & 32'hFFFF_FFFC;
         in_mem_ready     = 1'($urandom_range(0, 1));
         in_mem_read_data = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check_value("idle_busy", out_busy, 0);
         check_value("idle_req", out_mem_read_en, 0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bit [31:0] offs [3];
      bit [31:0] va;
      offs[0] = 32'h0000_1000;
      offs[1] = 32'h0000_0000;
      offs[2] = 32'hFFFF_F000;
      mem_override[32'h0000_1200] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

      reset            = 1'b0;
      in_read_en       = 1'b0;
      in_addr          = 32'd0;
      in_os_offset     = 32'h1000;
      in_mem_ready     = 1'b0;
      in_mem_read_data = '0;
      model_reset();
      #23;
      check_value("reset_req", out_mem_read_en, 0);
      check_value("reset_addr", out_mem_addr, 32'd0);
      check_value("write_en", out_mem_write_en, 0);
      check_value("write_data", out_mem_write_data[31:0], 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check_value("post_reset_busy", out_busy, 0);
      check_value("post_reset_req", out_mem_read_en, 0);
      check_value("post_reset_hit", out_hit, 0);
      @(posedge clk); #1;

      // Cold fetch and same-line hits
      do_fetch(32'h200, 32'h1000, 2);
      do_fetch(32'h204, 32'h1000, 0);
      do_fetch(32'h208, 32'h1000, 0);
      do_fetch(32'h20C, 32'h1000, 0);
      // Round-robin eviction of page 0
      do_fetch(32'h1000, 32'h1000, 1);
      do_fetch(32'h2000, 32'h1000, 0);
      do_fetch(32'h3000, 32'h1000, 3);
      do_fetch(32'h4000, 32'h1000, 1);
      do_fetch(32'h0000, 32'h1000, 0);
      // Index conflict between PA 0x1200 and 0x1240
      do_fetch(32'h240, 32'h1000, 1);
      do_fetch(32'h200, 32'h1000, 2);
      // Translation wrapping modulo 2^32
      do_fetch(32'h5010, 32'hFFFF_F000, 1);
      do_idle(4);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            do_idle(int'($urandom_range(1, 3)));
         end else begin
            va = (32'($urandom_range(0, 5)) << 12) | (32'($urandom_range(0, 7)) << 4) |
                 (32'($urandom_range(0, 3)) << 2);
            do_fetch(va, offs[$urandom_range(0, 2)], int'($urandom_range(0, 3)));
         end
      end

      // Reset during MEM_WAIT drops the request and leaves the line invalid
      do_idle(1);
      reset = 1'b0;
      #1;
      reset = 1'b1;
      model_reset();
      @(posedge clk); #1;
      in_addr      = 32'h200;
      in_os_offset = 32'h1000;
      in_read_en   = 1'b1;
      in_mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_value("abort_req_before", out_mem_read_en, 1);
      #1;
      reset            = 1'b0;
      in_mem_ready     = 1'b1;
      in_mem_read_data = mem_line(32'h1200);
      #1;
      check_value("abort_req_drop", out_mem_read_en, 0);
      check_value("abort_addr_clear", out_mem_addr, 32'd0);
      @(posedge clk); #1;
      reset        = 1'b1;
      in_mem_ready = 1'b0;
      model_reset();
      do_fetch(32'h200, 32'h1000, 1);
      do_idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
